pwm_burst_array: RTL
====================

# pwm_burst_array

Multi-channel, parametrised PWM/burst generator that replaces the fixed six-channel PWM engine behind the UART register mapper. Each channel has its own period, high time, start-phase delay and pulse count, with double-buffered configuration so that reprogramming never produces a glitch. It sits between the register mapper (config writes, start/stop strobes) and the BUFG/ODDR/OBUFDS output stage at the top level.

## Interface
- NUM_CH, 6, number of PWM channels (1–32)
- CNT_W, 17, width of the PERIOD/HIGH/PHASE counters
- NUM_W, 8, width of the pulse-count register
- sys_clk  in  1  PWM clock (100 MHz domain)
- sys_rst  in  1  asynchronous reset, active-high
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  $clog2(NUM_CH)  target channel; an index ≥ NUM_CH makes the write a no-op
- cfg_addr  in  2  register select: 0 PERIOD, 1 HIGH, 2 PHASE, 3 COUNT
- cfg_wdata  in  CNT_W  write data; COUNT uses bits [NUM_W-1:0]
- start  in  NUM_CH  per-channel start pulse
- stop  in  NUM_CH  per-channel abort pulse
- pwm_out  out  NUM_CH  registered PWM outputs
- pwm_busy  out  NUM_CH  channel in DELAY or RUN
- pwm_done  out  NUM_CH  one-cycle pulse when a finite burst completes

## Operation
- Every channel has a staged register set (written via cfg_*) and an active set (used by the counters).
- Staged reset values: PERIOD=2, HIGH=1, PHASE=0, COUNT=1.
- PERIOD writes below 2 are clamped to 2.
- Staged→active copy happens on an accepted start and on the last cycle of every period. New values therefore take effect at a period boundary only.
- A write in the same cycle as a load is not seen by that load; the old staged value is copied.
- Per-channel FSM states: IDLE, DELAY, RUN.
  - IDLE: start → DELAY if PHASE>0, otherwise → RUN. pwm_out=0, busy=0.
  - DELAY: phase counter runs 0..PHASE-1, then → RUN. pwm_out=0, busy=1.
  - RUN: period counter cnt runs 0..PERIOD-1 and wraps. pwm_out = (cnt < HIGH). HIGH=0 gives constant low; HIGH ≥ PERIOD gives constant high.
- At cnt==PERIOD-1 the pulse counter (NUM_W bits) increments.
  - If COUNT≠0 and the pulse counter reaches COUNT: → IDLE and pwm_done pulses.
  - If COUNT=0 the channel runs until stop. The pulse counter saturates and does not wrap.
- stop in any non-IDLE state: → IDLE next cycle, pwm_out=0, no done pulse.
- start and stop in the same cycle: stop wins.
- start while busy is ignored (no restart, no reload).
- Channels are fully independent. Starting several channels in the same cycle with equal PHASE produces edge-aligned outputs.

## Timing
- Reset (asynchronous assert, release on the clock edge): pwm_out=0, pwm_busy=0, pwm_done=0, all FSMs IDLE, all counters 0, staged registers at their defaults.
- start sampled high at edge t, PHASE=0: busy=1 and pwm_out=1 (if HIGH>0) from cycle t+1.
- With PHASE=P: first high cycle is t+1+P; busy=1 from t+1.
- Output period is exactly PERIOD cycles and high time exactly min(HIGH, PERIOD) cycles. No dead cycle between consecutive periods.
- Finite burst: the last RUN cycle is t+P+COUNT·PERIOD. In the following cycle pwm_done=1 for one cycle and busy=0.
- stop at edge s: pwm_out=0 and busy=0 from cycle s+1.
- cfg write at edge w is visible to any load at edge w+1 or later.

## Structure
- Package pwm_pkg holds:
  - register address constants (REG_PERIOD=0, REG_HIGH=1, REG_PHASE=2, REG_COUNT=3)
  - the FSM state enum
  - the default staged values
- Sub-module pwm_burst_ch implements one channel: staged and active registers, FSM, counters. The top generates NUM_CH instances and decodes cfg_ch into per-channel write enables.
- The top adds no output registering beyond that in pwm_burst_ch.

## Test plan
- Basic burst on ch0 with PERIOD=10, HIGH=3, PHASE=0, COUNT=2, start at cycle 0: pwm_out high in cycles 1–3 and 11–13, busy high in 1–20, pwm_done in cycle 21.
- Phase and alignment: ch1 PHASE=5 and ch2 PHASE=0, same config as above, started together: ch1 output is ch2 delayed by exactly 5 cycles; both done pulses are 5 cycles apart.
- Shadow update: COUNT=0, PERIOD=10, HIGH=3; write HIGH=7 mid-period: the current period keeps 3 high cycles, the next has 7; no runt pulse.
- Boundaries:
  - PERIOD write of 1 reads back as period 2.
  - HIGH=0 gives constant low.
  - HIGH=12 with PERIOD=10 gives constant high.
  - COUNT=0 is still running after 300 periods, with no done pulse.
- Stop/start collisions: start+stop in the same cycle leaves the channel idle; stop mid-RUN clears pwm_out the next cycle with no done pulse; start while busy leaves the waveform unchanged.
- Reset mid-burst: assert sys_rst asynchronously during RUN → all outputs 0 immediately; after release, staged registers read back at their defaults.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM/burst channel array: register map, channel
// state encoding and the staged-register values loaded at reset.
package pwm_pkg;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_HIGH   = 2'd1;
    localparam logic [1:0] REG_PHASE  = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } pwm_state_e;

    localparam int unsigned DEF_PERIOD = 2;
    localparam int unsigned DEF_HIGH   = 1;
    localparam int unsigned DEF_PHASE  = 0;
    localparam int unsigned DEF_COUNT  = 1;

    // Shortest period that still gives one low and one high cycle.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_burst_ch.sv
// One PWM/burst channel: staged and active configuration, IDLE/DELAY/RUN
// sequencer, shared phase/period counter and saturating pulse counter.
module pwm_burst_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = 17,
    parameter int NUM_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             start,
    input  logic             stop,
    output logic             pwm_out,
    output logic             pwm_busy,
    output logic             pwm_done
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
        logic [NUM_W-1:0] count;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        period: CNT_W'(DEF_PERIOD),
        high:   CNT_W'(DEF_HIGH),
        phase:  CNT_W'(DEF_PHASE),
        count:  NUM_W'(DEF_COUNT)
    };

    cfg_t             stg_q,   stg_d;
    cfg_t             act_q,   act_d;
    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NUM_W-1:0] pulse_q, pulse_d;
    logic             out_q,   out_d;
    logic             done_q,  done_d;

    always_comb begin
        // NOTE: every _d starts from its _q (or a safe constant) so no branch can infer a latch.
        stg_d   = stg_q;
        act_d   = act_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;

        if (cfg_we) begin
            case (cfg_addr)
                REG_PERIOD: stg_d.period = (cfg_wdata < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : cfg_wdata;
                REG_HIGH:   stg_d.high   = cfg_wdata;
                REG_PHASE:  stg_d.phase  = cfg_wdata;
                default:    stg_d.count  = cfg_wdata[NUM_W-1:0];
            endcase
        end

        // Loads read stg_q, so a write in the same cycle is only seen by later loads.
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    act_d   = stg_q;
                    cnt_d   = '0;
                    pulse_d = '0;
                    state_d = (stg_q.phase != '0) ? ST_DELAY : ST_RUN;
                end
            end
            ST_DELAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == act_q.phase - CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == act_q.period - CNT_W'(1)) begin
                    cnt_d = '0;
                    act_d = stg_q;
                    if (pulse_q != '1) begin
                        pulse_d = pulse_q + NUM_W'(1);
                    end
                    // >= rather than == so a smaller COUNT reloaded mid-burst still terminates.
                    if (act_q.count != '0 && pulse_d >= act_q.count) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output is decided from next-cycle state so pwm_out stays a plain flop.
        out_d = (state_d == ST_RUN) && (cnt_d < act_d.high);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            // NOTE: the staged set is reset too, so a start straight out of reset runs the defaults.
            stg_q   <= CFG_DEFAULT;
            act_q   <= CFG_DEFAULT;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            stg_q   <= stg_d;
            act_q   <= act_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign pwm_out  = out_q;
    assign pwm_busy = (state_q != ST_IDLE);
    assign pwm_done = done_q;

endmodule

// File: rtl/pwm_burst_array.sv
// Array of independent PWM/burst channels; decodes the shared config bus into
// per-channel write enables. Outputs come straight from the channel flops.
module pwm_burst_array #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 17,
    parameter int NUM_W  = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_addr,
    input  logic [CNT_W-1:0]  cfg_wdata,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] pwm_busy,
    output logic [NUM_CH-1:0] pwm_done
);

    logic [NUM_CH-1:0] ch_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Indices at or above NUM_CH match no channel, so such writes are dropped.
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        pwm_burst_ch #(
            .CNT_W (CNT_W),
            .NUM_W (NUM_W)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .cfg_we    (ch_we[i]),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .start     (start[i]),
            .stop      (stop[i]),
            .pwm_out   (pwm_out[i]),
            .pwm_busy  (pwm_busy[i]),
            .pwm_done  (pwm_done[i])
        );
    end

endmodule
